// File: rtl/usb_rx_demux_pkg.sv
// Shared definitions for the USB receive demultiplexer: header layout,
// sequencer state encoding and register map.
package usb_rx_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header word layout, MSB first: magic, channel, reserved, length.
    typedef struct packed {
        logic [7:0]  magic;
        logic [3:0]  ch;
        logic [3:0]  rsvd;
        logic [15:0] len;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_e;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_PKT_COUNT = 8'h08;
    localparam logic [7:0] REG_ERR_MAGIC = 8'h0C;
    localparam logic [7:0] REG_ERR_DROP  = 8'h10;
    localparam logic [7:0] REG_CLEAR     = 8'h14;

endpackage

// File: rtl/usb_rx_demux_sat_counter16.sv
// 16-bit event counter that sticks at its maximum; clear has priority.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'h0000;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_rx_demux.sv
// Drains the USB receive FIFO, parses one-word packet headers and steers
// payloads to NUM_CH valid/ready streams; configured over the slave bus.
module usb_rx_demux
    import usb_rx_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              in_pop,
    input  logic              in_nempty,
    input  logic [31:0]       in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [31:0]       out_data,
    output logic              out_last
);

    state_e             state_q, state_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [3:0]         ch_q, ch_d;
    logic               enable_q, enable_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [31:0]        pkt_count_q, pkt_count_d;
    logic               mem_ready_q;
    logic [31:0]        mem_rdata_q, mem_rdata_d;

    hdr_t               hdr_s;
    logic [15:0]        mask_ext_s, ready_ext_s;
    logic               hdr_ok_s;
    logic               pop_s, last_s;
    logic [NUM_CH-1:0]  valid_s;
    logic               pkt_inc_s, magic_inc_s, drop_inc_s;
    logic               bus_hit_s, bus_wr_s, clr_s;
    logic [7:0]         reg_off_s;
    logic [31:0]        ctrl_rd_s, status_rd_s;
    logic [15:0]        err_magic_s, err_drop_s;
    logic               unused_s;

    assign hdr_s = hdr_t'(in_data);

    // Widen mask/ready to 16 channels so any 4-bit channel indexes safely;
    // channels at or above NUM_CH read as masked and never ready.
    always_comb begin
        mask_ext_s               = 16'h0000;
        ready_ext_s              = 16'h0000;
        mask_ext_s[NUM_CH-1:0]   = mask_q;
        ready_ext_s[NUM_CH-1:0]  = out_ready;
    end

    assign hdr_ok_s = mask_ext_s[hdr_s.ch];

    // Sequencer next-state, FIFO pop and stream outputs
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ch_d        = ch_q;
        pop_s       = 1'b0;
        valid_s     = '0;
        last_s      = 1'b0;
        pkt_inc_s   = 1'b0;
        magic_inc_s = 1'b0;
        drop_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q) state_d = ST_HDR;
                else          state_d = ST_IDLE;
            end
            ST_HDR: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (in_nempty) begin
                    pop_s = 1'b1;
                    if (hdr_s.magic != HDR_MAGIC) begin
                        magic_inc_s = 1'b1;
                    end else if (!hdr_ok_s) begin
                        drop_inc_s = 1'b1;
                        if (hdr_s.len != 16'h0000) begin
                            remaining_d = hdr_s.len;
                            state_d     = ST_DROP;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else if (hdr_s.len == 16'h0000) begin
                        pkt_inc_s = 1'b1;
                    end else begin
                        ch_d        = hdr_s.ch;
                        remaining_d = hdr_s.len;
                        state_d     = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                valid_s = NUM_CH'(in_nempty) << ch_q;
                last_s  = (remaining_q == 16'h0001);
                pop_s   = in_nempty & ready_ext_s[ch_q];
                if (pop_s) begin
                    remaining_d = remaining_q - 16'h0001;
                    if (remaining_q == 16'h0001) begin
                        pkt_inc_s = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                pop_s = in_nempty;
                if (pop_s) begin
                    remaining_d = remaining_q - 16'h0001;
                    if (remaining_q == 16'h0001) state_d = ST_HDR;
                    else                         state_d = ST_DROP;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One access per request: the acknowledge cycle itself never re-triggers
    assign bus_hit_s = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !mem_ready_q;
    assign bus_wr_s  = bus_hit_s && (mem_wstrb != 4'b0000);
    assign reg_off_s = mem_addr[7:0];
    assign clr_s     = bus_wr_s && (reg_off_s == REG_CLEAR);

    // Register map: control writes, packet counter and read mux
    always_comb begin
        enable_d    = enable_q;
        mask_d      = mask_q;
        ctrl_rd_s   = 32'h0000_0000;
        ctrl_rd_s[0]              = enable_q;
        ctrl_rd_s[8 +: NUM_CH]    = mask_q;
        status_rd_s = {remaining_q, 8'h00, ch_q, 2'b00, state_q};
        if (bus_wr_s && (reg_off_s == REG_CTRL)) begin
            enable_d = mem_wdata[0];
            mask_d   = mem_wdata[8 +: NUM_CH];
        end else begin
            enable_d = enable_q;
        end
        if (clr_s)          pkt_count_d = 32'h0000_0000;
        else if (pkt_inc_s) pkt_count_d = pkt_count_q + 32'h0000_0001;
        else                pkt_count_d = pkt_count_q;
        mem_rdata_d = 32'h0000_0000;
        if (bus_hit_s && !bus_wr_s) begin
            case (reg_off_s)
                REG_CTRL:      mem_rdata_d = ctrl_rd_s;
                REG_STATUS:    mem_rdata_d = status_rd_s;
                REG_PKT_COUNT: mem_rdata_d = pkt_count_q;
                REG_ERR_MAGIC: mem_rdata_d = {16'h0000, err_magic_s};
                REG_ERR_DROP:  mem_rdata_d = {16'h0000, err_drop_s};
                default:       mem_rdata_d = 32'h0000_0000;
            endcase
        end else begin
            mem_rdata_d = 32'h0000_0000;
        end
    end

    // State and register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'h0000;
            ch_q        <= 4'h0;
            enable_q    <= 1'b0;
            mask_q      <= '1;
            pkt_count_q <= 32'h0000_0000;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ch_q        <= ch_d;
            enable_q    <= enable_d;
            mask_q      <= mask_d;
            pkt_count_q <= pkt_count_d;
            mem_ready_q <= bus_hit_s;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    sat_counter16 u_err_magic (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_s),
        .inc_i (magic_inc_s),
        .cnt_o (err_magic_s)
    );

    sat_counter16 u_err_drop (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_s),
        .inc_i (drop_inc_s),
        .cnt_o (err_drop_s)
    );

    assign unused_s  = ^{mem_wdata[31:8+NUM_CH], mem_wdata[7:1]};
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign in_pop    = pop_s;
    assign out_valid = valid_s;
    assign out_data  = in_data;
    assign out_last  = last_s;

endmodule

// File: tb/tb_usb_rx_demux.sv
// Self-checking bench for usb_rx_demux: FIFO and stream modelled with queues,
// expected traffic and counters derived by parsing the pushed word list.
`timescale 1ns/1ps
module tb_usb_rx_demux;

    localparam int          NUM_CH = 4;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_PKT  = BASE + 32'h08;
    localparam logic [31:0] A_MAG  = BASE + 32'h0C;
    localparam logic [31:0] A_DROP = BASE + 32'h10;
    localparam logic [31:0] A_CLR  = BASE + 32'h14;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid, mem_ready;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;
    logic              in_pop, in_nempty;
    logic [31:0]       in_data;
    logic [NUM_CH-1:0] out_valid, out_ready;
    logic [31:0]       out_data;
    logic              out_last;

    usb_rx_demux #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .in_pop(in_pop), .in_nempty(in_nempty), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [31:0] data; logic last; int cyc; } xfer_t;

    logic [31:0]       fifo[$];
    logic [31:0]       stim[$];
    xfer_t             got[$];
    xfer_t             expq[$];
    int                errors = 0, checks = 0, cyc = 0, ready_mode = 0;
    int                exp_pkt = 0, exp_magic = 0, exp_drop = 0;
    logic [15:0]       cur_mask = 16'h000F;
    logic              seen_ready = 1'b0;
    logic [31:0]       seen_rdata = 32'h0;
    logic              prev_stall = 1'b0;
    logic [NUM_CH-1:0] prev_valid = '0;
    logic [31:0]       prev_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        in_nempty = (fifo.size() != 0);
        in_data   = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic load(input logic [31:0] w);
        fifo.push_back(w);
        stim.push_back(w);
        sync_fifo();
    endtask

    // One clock: observe at negedge, apply FIFO pop at posedge, new inputs #1 later.
    task automatic tick();
        logic pop;
        int   c;
        c = 0;
        @(negedge clk);
        pop        = in_pop;
        seen_ready = mem_ready;
        seen_rdata = mem_rdata;
        if (prev_stall) begin
            chk("hold_valid", 32'(prev_valid), 32'(out_valid));
            chk("hold_data", out_data, prev_data);
        end
        if (pop) chk("pop_nonempty", {31'd0, in_nempty}, 32'd1);
        if (out_valid != '0) begin
            chk("onehot", {31'd0, $onehot(out_valid)}, 32'd1);
            for (int k = 0; k < NUM_CH; k++) if (out_valid[k]) c = k;
            chk("pop_vs_ready", {31'd0, pop}, {31'd0, out_ready[c]});
            if (out_ready[c]) got.push_back('{c, out_data, out_last, cyc});
            prev_stall = !out_ready[c];
            prev_valid = out_valid;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        #1;
        sync_fifo();
        case (ready_mode)
            0: out_ready = '1;
            1: begin out_ready = '1; out_ready[1] = ~cyc[0]; end
            default: out_ready = NUM_CH'($urandom);
        endcase
    endtask

    // Request is sampled at the edge ending tick 1, so the ack shows in tick 2.
    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input bit expect_ack,
                              output logic [31:0] rdata);
        int n;
        bit acked;
        n = 0;
        acked = 1'b0;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick();
            n++;
            if (seen_ready) acked = 1'b1;
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        rdata = seen_rdata;
        if (expect_ack) chk("ack_latency", n, 32'd2);
        else            chk("no_ack", {31'd0, acked}, 32'd0);
        tick();
        chk("ack_pulse", {31'd0, seen_ready}, 32'd0);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        bus_access(addr, wdata, 4'hF, 1'b1, d);
        if (addr == A_CTRL) cur_mask = {12'h000, wdata[11:8]};
        if (addr == A_CLR) begin exp_pkt = 0; exp_magic = 0; exp_drop = 0; end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        bus_access(addr, 32'h0, 4'h0, 1'b1, d);
    endtask

    // Reference: walk the word list packet by packet.
    task automatic model();
        int i, c, len;
        logic [31:0] w;
        i = 0;
        while (i < stim.size()) begin
            w = stim[i];
            i++;
            if (w[31:24] != 8'hA5) begin
                if (exp_magic < 65535) exp_magic++;
            end else begin
                c   = int'(w[23:20]);
                len = int'(w[15:0]);
                if (c >= NUM_CH || !cur_mask[c]) begin
                    if (exp_drop < 65535) exp_drop++;
                    i += len;
                end else begin
                    for (int k = 0; k < len; k++) expq.push_back('{c, stim[i+k], (k == len-1), 0});
                    i += len;
                    exp_pkt++;
                end
            end
        end
        stim.delete();
    endtask

    task automatic run_stream(input string tag);
        int budget;
        budget = fifo.size() * 8 + 100;
        model();
        for (int i = 0; i < budget && fifo.size() != 0; i++) tick();
        chk({tag, "_drained"}, fifo.size(), 32'd0);
        tick();
        tick();
        chk({tag, "_n"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk({tag, "_data"}, got[i].data, expq[i].data);
            chk({tag, "_ch"}, got[i].ch, expq[i].ch);
            chk({tag, "_last"}, {31'd0, got[i].last}, {31'd0, expq[i].last});
        end
    endtask

    task automatic check_counters(input string tag);
        logic [31:0] r;
        bus_read(A_PKT, r);  chk({tag, "_pkt"}, r, exp_pkt);
        bus_read(A_MAG, r);  chk({tag, "_magic"}, r, exp_magic);
        bus_read(A_DROP, r); chk({tag, "_drop"}, r, exp_drop);
    endtask

    task automatic reset_track();
        got.delete();
        expq.delete();
    endtask

    initial begin
        logic [31:0] r, w;
        int          len, ch, kind;
        rst = 1'b1; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        out_ready = '1; in_nempty = 1'b0; in_data = 32'h0;
        load(32'hA510_0003); load(32'h11); load(32'h22); load(32'h33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pop", {31'd0, in_pop}, 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_last", {31'd0, out_last}, 32'd0);
            chk("rst_ready", {31'd0, mem_ready}, 32'd0);
            chk("rst_rdata", mem_rdata, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_no_pop", fifo.size(), 32'd4);
        bus_read(A_CTRL, r); chk("rst_ctrl", r, 32'h0000_0F00);
        bus_read(A_STAT, r); chk("rst_status", r, 32'h0);
        bus_read(A_PKT, r);  chk("rst_pkt", r, 32'h0);

        // Basic packet, channel 1, full throughput
        reset_track();
        bus_write(A_CTRL, 32'h0000_0F01);
        run_stream("t1");
        if (got.size() == 3) begin
            chk("t1_consec", got[2].cyc - got[0].cyc, 32'd2);
            chk("t1_w0", got[0].data, 32'h11);
            chk("t1_w2", got[2].data, 32'h33);
            chk("t1_last", {31'd0, got[2].last}, 32'd1);
        end
        bus_read(A_PKT, r); chk("t1_pkt", r, 32'd1);

        // Same packet with out_ready[1] toggling
        reset_track();
        ready_mode = 1;
        load(32'hA510_0003); load(32'h11); load(32'h22); load(32'h33);
        run_stream("t2");
        ready_mode = 0;

        // Bad magic then good 1-word packet on channel 0
        reset_track();
        load(32'hDEAD_BEEF); load(32'hA500_0001); load(32'h55);
        run_stream("t3");
        if (got.size() == 1) chk("t3_ch0", got[0].ch, 32'd0);
        check_counters("t3");

        // Masked channel drop, then empty packet
        bus_write(A_CLR, 32'h1);
        bus_write(A_CTRL, 32'h0000_0B01);
        reset_track();
        load(32'hA520_0002); load(32'hCAFE_0001); load(32'hCAFE_0002); load(32'hA500_0000);
        run_stream("t4");
        bus_read(A_DROP, r); chk("t4_drop", r, 32'd1);
        bus_read(A_PKT, r);  chk("t4_pkt", r, 32'd1);
        check_counters("t4");

        // Unmapped offsets and out-of-range requests
        bus_read(BASE + 32'h18, r); chk("unmapped_rd", r, 32'h0);
        bus_write(BASE + 32'h18, 32'hFFFF_FFFF);
        bus_read(A_CTRL, r); chk("unmapped_wr", r, 32'h0000_0B01);
        bus_access(BASE + 32'h100, 32'h0, 4'h0, 1'b0, r);
        bus_access(32'h0000_0004, 32'h0, 4'h0, 1'b0, r);

        // Enable cleared mid-packet: packet completes, then block idles
        bus_write(A_CTRL, 32'h0000_0F01);
        reset_track();
        ready_mode = 1;
        load(32'hA510_0004); load(32'h1); load(32'h2); load(32'h3); load(32'h4);
        tick(); tick();
        bus_write(A_CTRL, 32'h0000_0F00);
        run_stream("t5");
        ready_mode = 0;
        fifo.push_back(32'hA500_0001); fifo.push_back(32'h77); sync_fifo();
        for (int i = 0; i < 10; i++) tick();
        chk("t5_no_pop", fifo.size(), 32'd2);
        bus_read(A_STAT, r); chk("t5_status", r, 32'h0000_0010);
        fifo.delete(); sync_fifo();

        // Randomised traffic against the parsing model
        ready_mode = 2;
        for (int round = 0; round < 3; round++) begin
            bus_write(A_CTRL, {20'h0, 4'($urandom_range(0, 15)), 8'h01});
            reset_track();
            for (int p = 0; p < 25; p++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    w = $urandom;
                    if (w[31:24] == 8'hA5) w[31:24] = 8'h5A;
                    load(w);
                end else begin
                    ch  = (kind < 7) ? $urandom_range(0, NUM_CH - 1) : $urandom_range(0, 15);
                    len = $urandom_range(0, 5);
                    w   = {8'hA5, 4'(ch), 4'($urandom_range(0, 15)), 16'(len)};
                    load(w);
                    for (int k = 0; k < len; k++) load($urandom);
                end
            end
            run_stream("rnd");
            check_counters("rnd");
        end
        ready_mode = 0;

        // Magic-error saturation and clear beating an increment
        bus_write(A_CTRL, 32'h0000_0F01);
        bus_write(A_CLR, 32'h1);
        reset_track();
        for (int i = 0; i < 65535; i++) load(32'h0000_0000);
        run_stream("sat");
        bus_read(A_MAG, r); chk("sat_ffff", r, 32'h0000_FFFF);
        load(32'h0000_0001);
        run_stream("sat1");
        bus_read(A_MAG, r); chk("sat_hold", r, 32'h0000_FFFF);
        fifo.push_back(32'h1234_5678); sync_fifo();
        bus_write(A_CLR, 32'h1);
        chk("clr_popped", fifo.size(), 32'd0);
        check_counters("clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
